// File: rtl/backbone_pkg.sv
// Shared shape constants, data types and small helpers for the conv1 GEMM backbone block.
package backbone_pkg;

    localparam int CIN    = 1;
    localparam int H_IN   = 8;
    localparam int W_IN   = 8;
    localparam int COUT   = 4;
    localparam int KH     = 3;
    localparam int KW     = 3;
    localparam int STRIDE = 1;
    localparam int PAD    = 1;
    localparam int H_OUT  = (H_IN + 2 * PAD - KH) / STRIDE + 1;
    localparam int W_OUT  = (W_IN + 2 * PAD - KW) / STRIDE + 1;

    typedef logic signed [15:0] data_t;
    typedef logic signed [31:0] acc_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CIB = bits_for(CIN);
    localparam int KHB = bits_for(KH);
    localparam int KWB = bits_for(KW);
    localparam int HOB = bits_for(H_OUT);
    localparam int WOB = bits_for(W_OUT);
    localparam int HIB = bits_for(H_IN);
    localparam int WIB = bits_for(W_IN);

    // True when a padded-plane coordinate lands inside the real feature map.
    function automatic logic in_range(input int v, input int lim);
        return (v >= 0) && (v < lim);
    endfunction

endpackage

// File: rtl/conv1_gemm_mac_lane.sv
// One output-channel MAC lane: 16x16 signed product into a wrapping 32-bit accumulator.
module conv1_gemm_mac_lane
    import backbone_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clear,
    input  logic  en,
    input  logic  last,
    input  data_t weight,
    input  data_t x,
    output acc_t  wb
);

    acc_t acc_r;
    acc_t prod_s;
    acc_t sum_s;

    // Full-precision product and running sum; the sum is the writeback value on the last tap.
    always_comb begin
        prod_s = acc_t'(weight) * acc_t'(x);
        sum_s  = acc_r + prod_s;
    end

    // Accumulator: cleared on a new run and after each pixel's final tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (clear) begin
            acc_r <= '0;
        end else if (en) begin
            if (last) begin
                acc_r <= '0;
            end else begin
                acc_r <= sum_s;
            end
        end
    end

    assign wb = sum_s;

endmodule

// File: rtl/conv1_small_gemm.sv
// 3x3/stride-1/pad-1 convolution evaluated as im2col x weight GEMM, one tap per cycle.
// Optional macro CONV1_GEMM_BUSY_EN adds a busy output (high in RUN and DONE).
module conv1_small_gemm
    import backbone_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
`ifdef CONV1_GEMM_BUSY_EN
    output logic  busy,
`endif
    output logic  done,
    input  data_t fmap_i   [CIN][H_IN][W_IN],
    input  data_t weight_i [COUT][CIN][KH][KW],
    output acc_t  out_o    [COUT][H_OUT][W_OUT]
);

    localparam logic [CIB-1:0] CI_LAST = CIB'(CIN - 1);
    localparam logic [KHB-1:0] KH_LAST = KHB'(KH - 1);
    localparam logic [KWB-1:0] KW_LAST = KWB'(KW - 1);
    localparam logic [HOB-1:0] OH_LAST = HOB'(H_OUT - 1);
    localparam logic [WOB-1:0] OW_LAST = WOB'(W_OUT - 1);

    logic [1:0]     state_r;
    logic [1:0]     state_nxt_s;
    logic [CIB-1:0] ci_r;
    logic [KHB-1:0] kh_r;
    logic [KWB-1:0] kw_r;
    logic [HOB-1:0] oh_r;
    logic [WOB-1:0] ow_r;
    logic           done_r;
    logic           launch_s;
    logic           run_s;
    logic           last_tap_s;
    logic           last_pix_s;
    int             ih_s;
    int             iw_s;
    data_t          x_s;
    acc_t           wb_s [COUT];

    assign launch_s   = (state_r == ST_IDLE) && start;
    assign run_s      = (state_r == ST_RUN);
    assign last_tap_s = (ci_r == CI_LAST) && (kh_r == KH_LAST) && (kw_r == KW_LAST);
    assign last_pix_s = (oh_r == OH_LAST) && (ow_r == OW_LAST);

    // Next-state logic: start is honoured only in IDLE; DONE lasts exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_tap_s && last_pix_s) state_nxt_s = ST_DONE;
                else                          state_nxt_s = ST_RUN;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, done pulse (one cycle after DONE) and optional busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= (state_r == ST_DONE);
        end
    end

`ifdef CONV1_GEMM_BUSY_EN
    logic busy_r;

    // Busy tracks the registered state so it is high exactly in RUN and DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
        end
    end

    assign busy = busy_r;
`endif

    assign done = done_r;

    // Raster counters: kw fastest, then kh, ci, ow, oh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ci_r <= '0; kh_r <= '0; kw_r <= '0; oh_r <= '0; ow_r <= '0;
        end else if (launch_s) begin
            ci_r <= '0; kh_r <= '0; kw_r <= '0; oh_r <= '0; ow_r <= '0;
        end else if (run_s) begin
            if (kw_r != KW_LAST) begin
                kw_r <= kw_r + KWB'(1);
            end else begin
                kw_r <= '0;
                if (kh_r != KH_LAST) begin
                    kh_r <= kh_r + KHB'(1);
                end else begin
                    kh_r <= '0;
                    if (ci_r != CI_LAST) begin
                        ci_r <= ci_r + CIB'(1);
                    end else begin
                        ci_r <= '0;
                        if (ow_r != OW_LAST) begin
                            ow_r <= ow_r + WOB'(1);
                        end else begin
                            ow_r <= '0;
                            if (oh_r != OH_LAST) oh_r <= oh_r + HOB'(1);
                            else                 oh_r <= '0;
                        end
                    end
                end
            end
        end
    end

    // Padded im2col fetch: taps that fall outside the map read as zero.
    always_comb begin
        ih_s = int'(oh_r) * STRIDE - PAD + int'(kh_r);
        iw_s = int'(ow_r) * STRIDE - PAD + int'(kw_r);
        x_s  = 16'sd0;
        if (in_range(ih_s, H_IN) && in_range(iw_s, W_IN)) begin
            x_s = fmap_i[ci_r][ih_s[HIB-1:0]][iw_s[WIB-1:0]];
        end else begin
            x_s = 16'sd0;
        end
    end

    for (genvar co = 0; co < COUT; co++) begin : g_lane
        conv1_gemm_mac_lane u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (launch_s),
            .en     (run_s),
            .last   (last_tap_s),
            .weight (weight_i[co][ci_r][kh_r][kw_r]),
            .x      (x_s),
            .wb     (wb_s[co])
        );
    end

    // Result array: written only when a pixel's last tap completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int co = 0; co < COUT; co++)
                for (int oh = 0; oh < H_OUT; oh++)
                    for (int ow = 0; ow < W_OUT; ow++)
                        out_o[co][oh][ow] <= '0;
        end else if (run_s && last_tap_s) begin
            for (int co = 0; co < COUT; co++)
                out_o[co][oh_r][ow_r] <= wb_s[co];
        end
    end

endmodule

// File: tb/tb_conv1_small_gemm.sv
// Directed bench for conv1_small_gemm: reset, identity, padding, wrap, back-to-back random and reset-abort.
module tb_conv1_small_gemm;
    import backbone_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  start;
    logic  done;
    data_t fmap    [CIN][H_IN][W_IN];
    data_t wgt     [COUT][CIN][KH][KW];
    acc_t  out     [COUT][H_OUT][W_OUT];
    acc_t  exp_out [COUT][H_OUT][W_OUT];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    lat;
    int    pulses;

`ifdef CONV1_GEMM_BUSY_EN
    logic busy;
`endif

    conv1_small_gemm dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef CONV1_GEMM_BUSY_EN
        .busy     (busy),
`endif
        .done     (done),
        .fmap_i   (fmap),
        .weight_i (wgt),
        .out_o    (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_out(input string tag);
        for (int co = 0; co < COUT; co++)
            for (int oh = 0; oh < H_OUT; oh++)
                for (int ow = 0; ow < W_OUT; ow++)
                    check($sformatf("%s[%0d][%0d][%0d]", tag, co, oh, ow),
                          out[co][oh][ow], exp_out[co][oh][ow]);
    endtask

    // Direct-form reference convolution with 32-bit wrapping accumulation.
    function automatic void ref_conv();
        int   ih, iw;
        acc_t acc;
        for (int co = 0; co < COUT; co++)
            for (int oh = 0; oh < H_OUT; oh++)
                for (int ow = 0; ow < W_OUT; ow++) begin
                    acc = 32'sd0;
                    for (int ci = 0; ci < CIN; ci++)
                        for (int kh = 0; kh < KH; kh++)
                            for (int kw = 0; kw < KW; kw++) begin
                                ih = oh * STRIDE - PAD + kh;
                                iw = ow * STRIDE - PAD + kw;
                                if (ih >= 0 && ih < H_IN && iw >= 0 && iw < W_IN)
                                    acc = acc + int'(wgt[co][ci][kh][kw]) * int'(fmap[ci][ih][iw]);
                            end
                    exp_out[co][oh][ow] = acc;
                end
    endfunction

    // Border class: number of in-map taps for a 3x3 pad-1 window at (i,j).
    function automatic int taps_at(input int i, input int j);
        int nr, nc;
        nr = (i == 0 || i == H_OUT - 1) ? 2 : 3;
        nc = (j == 0 || j == W_OUT - 1) ? 2 : 3;
        return nr * nc;
    endfunction

    task automatic fill_all(input data_t fv, input data_t wv);
        for (int i = 0; i < H_IN; i++)
            for (int j = 0; j < W_IN; j++)
                fmap[0][i][j] = fv;
        for (int co = 0; co < COUT; co++)
            for (int kh = 0; kh < KH; kh++)
                for (int kw = 0; kw < KW; kw++)
                    wgt[co][0][kh][kw] = wv;
    endtask

    task automatic fill_random();
        for (int i = 0; i < H_IN; i++)
            for (int j = 0; j < W_IN; j++)
                fmap[0][i][j] = data_t'($urandom_range(0, 65535));
        for (int co = 0; co < COUT; co++)
            for (int kh = 0; kh < KH; kh++)
                for (int kw = 0; kw < KW; kw++)
                    wgt[co][0][kh][kw] = data_t'($urandom_range(0, 65535));
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits for done; optionally pokes start mid-RUN (at mid_k) and in the DONE cycle.
    task automatic wait_done(input int mid_k, input bit done_poke, output int latency);
        latency = -1;
        for (int k = 1; k <= 2000; k++) begin
            tick();
            if (done) begin
                latency = k;
                start   = 1'b0;
                break;
            end
            if (k == mid_k)                start = 1'b1;
            else if (k == mid_k + 1)       start = 1'b0;
            if (done_poke && k == 576)     start = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fill_all(16'sd0, 16'sd0);
        repeat (3) tick();
        check("rst_done", done, 0);
        for (int co = 0; co < COUT; co++)
            for (int oh = 0; oh < H_OUT; oh++)
                for (int ow = 0; ow < W_OUT; ow++)
                    exp_out[co][oh][ow] = 32'sd0;
        compare_out("rst_out");
        rst_n = 1'b1;
        tick();

        // Identity kernel: centre tap of channel 0 only.
        for (int i = 0; i < H_IN; i++)
            for (int j = 0; j < W_IN; j++)
                fmap[0][i][j] = data_t'(8 * i + j);
        for (int co = 0; co < COUT; co++)
            for (int kh = 0; kh < KH; kh++)
                for (int kw = 0; kw < KW; kw++)
                    wgt[co][0][kh][kw] = 16'sd0;
        wgt[0][0][1][1] = 16'sd1;
        for (int co = 0; co < COUT; co++)
            for (int i = 0; i < H_OUT; i++)
                for (int j = 0; j < W_OUT; j++)
                    exp_out[co][i][j] = (co == 0) ? acc_t'(8 * i + j) : 32'sd0;
        launch();
        wait_done(0, 1'b0, lat);
        check("id_latency", lat, 577);
        compare_out("id");
        tick();
        check("id_done_width", done, 0);

        // Padding: all ones gives 9 / 6 / 4 by border class.
        fill_all(16'sd1, 16'sd1);
        for (int co = 0; co < COUT; co++)
            for (int i = 0; i < H_OUT; i++)
                for (int j = 0; j < W_OUT; j++)
                    exp_out[co][i][j] = acc_t'(taps_at(i, j));
        launch();
        wait_done(0, 1'b0, lat);
        check("pad_latency", lat, 577);
        compare_out("pad");

        // Wrap: each product is 2^30; sums wrap modulo 2^32.
        fill_all(-16'sd32768, -16'sd32768);
        for (int co = 0; co < COUT; co++)
            for (int i = 0; i < H_OUT; i++)
                for (int j = 0; j < W_OUT; j++)
                    case (taps_at(i, j))
                        4:       exp_out[co][i][j] = 32'sd0;
                        6:       exp_out[co][i][j] = -32'sd2147483648;
                        default: exp_out[co][i][j] = 32'sd1073741824;
                    endcase
        launch();
        wait_done(0, 1'b0, lat);
        check("wrap_latency", lat, 577);
        compare_out("wrap");

        // Five random cases back-to-back with stray start pulses in RUN and DONE.
        for (int c = 0; c < 5; c++) begin
            fill_random();
            ref_conv();
            launch();
            wait_done(150 + 60 * c, 1'b1, lat);
            check($sformatf("rnd%0d_latency", c), lat, 577);
            compare_out($sformatf("rnd%0d", c));
        end
        pulses = 0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (done) pulses++;
        end
        check("rnd_no_queued_run", pulses, 0);

        // Reset mid-run aborts; a fresh run then completes.
        fill_random();
        ref_conv();
        launch();
        for (int k = 1; k < 300; k++) tick();
        rst_n = 1'b0;
        #1;
        check("abort_done", done, 0);
        for (int co = 0; co < COUT; co++)
            for (int oh = 0; oh < H_OUT; oh++)
                for (int ow = 0; ow < W_OUT; ow++)
                    check($sformatf("abort_out[%0d][%0d][%0d]", co, oh, ow), out[co][oh][ow], 0);
        repeat (3) tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        launch();
        wait_done(0, 1'b0, lat);
        check("fresh_latency", lat, 577);
        compare_out("fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv1_small_gemm.md
# conv1_small_gemm

Small first-layer convolution engine computing a 3×3, stride-1, pad-1 convolution of a 1×8×8 signed 16-bit feature map into a 4×8×8 signed 32-bit output. It evaluates the convolution as a GEMM: the im2col vector of each output pixel, with K = CIN·KH·KW = 9 elements, is multiplied by the 4×9 weight matrix. It is a standalone backbone block: it takes whole-tensor array ports, runs on a single start pulse, and reports completion with `done`.

## Interface
Parameters, each given as name, default, meaning:
- CIN, 1, input channels
- H_IN / W_IN, 8 / 8, input height / width
- COUT, 4, output channels (one MAC lane each)
- KH / KW, 3 / 3, kernel size
- STRIDE, 1, convolution stride
- PAD, 1, zero padding on all sides
- H_OUT / W_OUT, 8 / 8, output size, equal to (H_IN+2·PAD−KH)/STRIDE+1

Ports, each given as name, direction, width, meaning:
- clk, in, 1, sole clock; all state updates on the rising edge
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, single-cycle run request; sampled only in IDLE
- done, out, 1, one-cycle completion pulse
- fmap_i, in, signed [15:0] [CIN][H_IN][W_IN], feature map; must be held stable from start until done
- weight_i, in, signed [15:0] [COUT][CIN][KH][KW], weights; must be held stable from start until done
- out_o, out, signed [31:0] [COUT][H_OUT][W_OUT], registered result array

## Operation
- The FSM has three states: IDLE, RUN and DONE.
  - IDLE → RUN when start=1. Counters oh, ow and tap are cleared, and the accumulators are cleared.
  - RUN steps tap from 0 to 8, then ow, then oh, in raster order.
  - RUN → DONE after the last tap of pixel (7,7). DONE lasts one cycle, then the FSM returns to IDLE.
- Each RUN cycle handles tap t = (ci, kh, kw), row-major with ci slowest.
  - ih = oh·STRIDE − PAD + kh and iw = ow·STRIDE − PAD + kw.
  - x = fmap_i[ci][ih][iw] when the indices are in range, else 0.
  - For every co in parallel: acc[co] += weight_i[co][ci][kh][kw]·x.
- On the last tap, the lane writes out_o[co][oh][ow] = acc[co] + final product, and acc[co] is cleared for the next pixel.
- Arithmetic:
  - Products are full 16×16 signed, giving 32 bits.
  - Accumulation is 32-bit two's complement and wraps on overflow, with no saturation.
- out_o is updated only on pixel-completion writes. It holds its value in IDLE and DONE, and until it is overwritten by the next run.
- start asserted in RUN or DONE is ignored, not queued.

## Timing
- Reset values: done=0, every out_o element 0, FSM in IDLE, counters and accumulators 0.
- Asserting rst_n low mid-run aborts the run immediately and restores the reset values; no done pulse is produced.
- Latency: if start is sampled at edge E, RUN occupies edges E+1 … E+576 (64 pixels × 9 taps).
  - done is high for the cycle following edge E+577.
  - All out_o values are final when done is high.
- Back-to-back runs: a start may arrive in the first IDLE cycle after DONE.

## Configuration
- Macro CONV1_GEMM_BUSY_EN.
  - Defined: adds output port busy (1 bit), which is high in RUN and DONE, and 0 in reset.
  - Undefined: the port is absent. Datapath behaviour is identical in both cases.

## Structure
- backbone_pkg holds:
  - the shared constants CIN, H_IN, W_IN, COUT, KH, KW, STRIDE, PAD, H_OUT, W_OUT;
  - the typedefs data_t (signed [15:0]) and acc_t (signed [31:0]).
- The top module contains the FSM, the counters and the padded im2col element fetch.
- Sub-module conv1_gemm_mac_lane, instantiated COUT times. Each instance takes its weight, x, clear and last-tap strobe, and owns one accumulator plus its writeback value.

## Test plan
- Reset check: hold rst_n low → done=0 and all 256 out_o elements are 0.
- Identity kernel. Stimulus: fmap[0][i][j] = 8i+j; weight[0][0][1][1] = 1 and every other weight 0; start. Required response: done pulses exactly 577 cycles after the start edge; out_o[0] equals fmap; out_o[1..3] are all 0.
- Padding check. Stimulus: all fmap values 1 and all weights 1. Required response, for every co: interior outputs 9, edge non-corner outputs 6, corner outputs 4.
- Wrap check. Stimulus: all fmap and all weights −32768. Required response: interior outputs 1073741824 (9·2^30 mod 2^32), corners 0, edges −2147483648.
- Five random cases run back-to-back, with start also pulsed mid-RUN. Required response: mid-RUN starts are ignored, and every case matches the reference convolution exactly.
- Reset mid-run. Stimulus: pull rst_n low at cycle 300 of RUN, then start again. Required response: out_o reads 0 immediately after reset, no done pulse occurs from the aborted run, and the fresh run completes correctly.
